// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with majority-vote bit sampling, feeding a first-word-fall-through byte FIFO.
// Framing and overrun conditions are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 57600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                         CLK100MHZ,
    input  logic                         resetn,
    input  logic                         Uart_RXD,
    output logic [7:0]                   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         frame_err,
    output logic                         overrun_err,
    output logic                         busy
);

    localparam int unsigned BIT_CYC  = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W    = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic             sync1_q, sync2_q;
    logic [2:0]       samp_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             overrun_q, overrun_d;

    logic maj_c, fall_c, pop_c, full_c, wr_en_c;

    // Majority of the three most recent synchronized samples around the decision point
    assign maj_c  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign fall_c = samp_q[0] & ~sync2_q;

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            samp_q      <= 3'b111;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= Uart_RXD;
            sync2_q     <= sync1_q;
            samp_q      <= {samp_q[1:0], sync2_q};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall_c) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_W'(HALF_CYC)) begin
                    if (maj_c) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    shift_d[idx_q] = maj_c;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    cnt_d = '0;
                    if (maj_c) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FIFO control: a full FIFO still accepts a push when the head is popped in the same cycle
    assign pop_c   = out_valid_q & out_ready;
    assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_en_c = push_q & (~full_c | pop_c);

    always_comb begin
        overrun_d = push_q & full_c & ~pop_c;
        wptr_d    = wptr_q + (AW + 1)'(wr_en_c);
        rptr_d    = rptr_q + (AW + 1)'(pop_c);
        level_d   = level_q;
        case ({wr_en_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        out_valid_d = (level_d != '0);
        out_data_d  = out_data_q;
        if (level_d != '0) begin
            if (wr_en_c && (rptr_d == wptr_q)) out_data_d = shift_q;
            else                               out_data_d = mem_q[rptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (wr_en_c) mem_q[wptr_q[AW-1:0]] <= shift_q;
    end

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign level       = level_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo; runs at a scaled-up baud so each bit spans 50 clocks.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ = 100000000;
    localparam int unsigned BAUD     = 2000000;
    localparam int unsigned DEPTH    = 16;
    localparam int          BIT_NS   = 500;
    localparam int          FAST_NS  = 485;
    localparam int          SLOW_NS  = 515;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_pops = 0;
    int         n_ferr = 0;
    int         n_ovr  = 0;
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    int         max_level = 0;
    bit         rand_ready = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK100MHZ   (clk),
        .resetn      (resetn),
        .Uart_RXD    (rxd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every accepted output beat is compared against the scoreboard head
    always @(negedge clk) begin
        if (resetn) begin
            if (out_valid && out_ready) begin
                n_pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop: got 0x%0h with nothing expected", out_data);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, e);
                    end
                end
            end
            if (frame_err)   n_ferr++;
            if (overrun_err) n_ovr++;
            if (int'(level) > max_level) max_level = int'(level);
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a good frame is accepted unless the consumer-side queue already holds DEPTH bytes
    task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_bit,
                              input bit expect_push, input bit pop_at_push);
        if (!stop_bit) exp_ferr++;
        else if (expect_push) begin
            if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back(b);
            else exp_ovr++;
        end
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_ns);
        end
        rxd = stop_bit;
        #(bit_ns);
    endtask

    task automatic pulse_ready_on_push();
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (dut.push_q) begin
                out_ready = 1'b1;
                seen      = 1'b1;
            end
        end
        check("push_seen", int'(seen), 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        cycles(4);
        check(name, exp_q.size(), 0);
        check({name, "_level"}, int'(level), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        rxd       = 1'b1;
        out_ready = 1'b0;
        resetn    = 1'b0;
        cycles(5);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun_err), 0);
        resetn = 1'b1;
        #1000;

        // Single byte
        out_ready = 1'b1;
        send_frame(8'h42, BIT_NS, 1'b1, 1'b1, 1'b0);
        cycles(60);
        check("single_pops", n_pops, 1);
        check("single_ferr", n_ferr, 0);
        check("single_ovr", n_ovr, 0);
        check("single_empty", exp_q.size(), 0);

        // Back-to-back frames, single stop bit, no idle gap
        max_level = 0;
        send_frame(8'h0A, BIT_NS, 1'b1, 1'b1, 1'b0);
        send_frame(8'h0D, BIT_NS, 1'b1, 1'b1, 1'b0);
        send_frame(8'hCC, BIT_NS, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) send_frame(8'($urandom), BIT_NS, 1'b1, 1'b1, 1'b0);
        cycles(60);
        check("b2b_pops", n_pops, 16);
        check("b2b_max_level", max_level, 1);
        check("b2b_empty", exp_q.size(), 0);

        // Short low glitch must not start a frame
        pops0 = n_pops;
        rxd = 1'b0;
        #120;
        rxd = 1'b1;
        cycles(60);
        check("glitch_busy", int'(busy), 0);
        check("glitch_level", int'(level), 0);
        check("glitch_pops", n_pops, pops0);

        // Framing error followed by a held-low line
        send_frame(8'h55, BIT_NS, 1'b0, 1'b1, 1'b0);
        #(3 * BIT_NS);
        check("ferr_hold_busy", int'(busy), 1);
        check("ferr_count", n_ferr, exp_ferr);
        check("ferr_level", int'(level), 0);
        rxd = 1'b1;
        cycles(20);
        check("ferr_release_busy", int'(busy), 0);

        // Overrun: 17 bytes into a 16-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int b = 0; b < 17; b++) send_frame(8'(b), BIT_NS, 1'b1, 1'b1, 1'b0);
        cycles(60);
        check("ovr_level", int'(level), 16);
        check("ovr_count", n_ovr, exp_ovr);
        drain("ovr_drain");

        // Full FIFO with a pop in the same cycle as the push
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), BIT_NS, 1'b1, 1'b1, 1'b0);
        cycles(20);
        check("full_level", int'(level), 16);
        fork
            send_frame(8'h77, BIT_NS, 1'b1, 1'b1, 1'b1);
            pulse_ready_on_push();
        join
        cycles(60);
        check("full_pop_level", int'(level), 16);
        check("full_pop_ovr", n_ovr, exp_ovr);
        drain("full_pop_drain");

        // Baud skew at both tolerance corners
        out_ready = 1'b1;
        send_frame(8'hA5, FAST_NS, 1'b1, 1'b1, 1'b0);
        #1000;
        send_frame(8'hA5, SLOW_NS, 1'b1, 1'b1, 1'b0);
        cycles(60);
        check("skew_empty", exp_q.size(), 0);

        // Reset during data bit 4 aborts the frame
        pops0 = n_pops;
        fork
            send_frame(8'hF3, BIT_NS, 1'b1, 1'b0, 1'b0);
            begin
                #(5 * BIT_NS + BIT_NS / 2);
                resetn = 1'b0;
                #100;
                resetn = 1'b1;
            end
        join
        cycles(60);
        check("rstmid_level", int'(level), 0);
        check("rstmid_valid", int'(out_valid), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_pops", n_pops, pops0);
        send_frame(8'($urandom), BIT_NS, 1'b1, 1'b1, 1'b0);
        cycles(60);
        check("rstmid_next", exp_q.size(), 0);

        // Random bytes, random gaps, randomly stalled consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom), BIT_NS, 1'b1, 1'b1, 1'b0);
            #($urandom_range(0, 3) * BIT_NS);
        end
        rand_ready = 1'b0;
        cycles(2);
        drain("rand_drain");
        check("final_ferr", n_ferr, exp_ferr);
        check("final_ovr", n_ovr, exp_ovr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
